// File: rtl/ahbl_cache_bridge.sv
// AHB-Lite slave front end for the write-through cache controller.
// Each accepted bus transfer becomes one single-cycle rd/wr pulse with a byte mask.
// The bus is stalled until the downstream path completes. Misaligned transfers and
// hung requests end with a two-cycle AHB ERROR response.
module ahbl_cache_bridge #(
    parameter int unsigned IGNORE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned CNT_W       = 13
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hready_resp,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy,
    output logic [7:0]  timeout_cnt
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StErr1, StErr2} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [CNT_W-1:0] ign_q;
    logic [CNT_W-1:0] to_q;

    logic       accept, legal, capture, done, expire;
    logic [3:0] mask;

    // htrans[0] only distinguishes SEQ from NONSEQ, which the bridge treats alike.
    logic unused_htrans;
    assign unused_htrans = htrans[0];

    assign accept = hsel && htrans[1] && hready;
    assign legal  = (hsize == 3'd0) ||
                    (hsize == 3'd1 && !haddr[0]) ||
                    (hsize == 3'd2 && haddr[1:0] == 2'b00);
    // Completion is only looked at once the ignore window has run out.
    assign done   = (ign_q == '0) && !mem_busy;
    assign expire = (TIMEOUT_CYC != 0) && (to_q == CNT_W'(1));

    // Byte-lane mask from the captured size and address.
    always_comb begin
        mask = 4'b1111;
        case (size_q)
            3'd0:    mask = 4'b0001 << addr_q[1:0];
            3'd1:    mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // Next-state and bus handshake outputs.
    always_comb begin
        state_d     = state_q;
        hready_resp = 1'b1;
        hresp       = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            StIdle, StResp, StErr2: begin
                hresp = (state_q == StErr2);
                if (accept) begin
                    capture = 1'b1;
                    state_d = legal ? StIssue : StErr1;
                end else if (state_q != StIdle) begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                hready_resp = 1'b0;
                state_d     = StWait;
            end
            StWait: begin
                hready_resp = 1'b0;
                if (done)        state_d = StResp;
                else if (expire) state_d = StErr1;
            end
            StErr1: begin
                hready_resp = 1'b0;
                hresp       = 1'b1;
                state_d     = StErr2;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_x) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Address-phase capture, request issue, wait counters and read-data return.
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            ign_q       <= '0;
            to_q        <= '0;
            hrdata      <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_mask    <= '0;
            timeout_cnt <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            if (capture) begin
                addr_q  <= haddr;
                write_q <= hwrite;
                size_q  <= hsize;
            end
            if (state_q == StIssue) begin
                mem_addr  <= addr_q;
                mem_mask  <= mask;
                mem_wdata <= hwdata;
                mem_wr_en <= write_q;
                mem_rd_en <= !write_q;
                ign_q     <= CNT_W'(IGNORE_CYC);
                to_q      <= CNT_W'(TIMEOUT_CYC);
            end else if (state_q == StWait) begin
                if (ign_q != '0) ign_q <= ign_q - CNT_W'(1);
                if (to_q != '0)  to_q  <= to_q - CNT_W'(1);
                if (done && !write_q) hrdata <= mem_rdata;
                if (!done && expire && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_cache_bridge.sv
// Directed bench for ahbl_cache_bridge: dut_a uses default parameters, dut_b a
// short 16-cycle timeout. Both see the same bus and memory-side stimulus.
module tb_ahbl_cache_bridge;

    logic        clk = 1'b0;
    logic        rst_x;
    logic        hsel, hwrite, hready, mem_busy;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, mem_rdata;

    logic        hready_resp_a, hresp_a, mem_rd_en_a, mem_wr_en_a;
    logic [31:0] hrdata_a, mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_mask_a;
    logic [7:0]  timeout_cnt_a;
    logic        hready_resp_b, hresp_b, mem_rd_en_b, mem_wr_en_b;
    logic [31:0] hrdata_b, mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_mask_b;
    logic [7:0]  timeout_cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ahbl_cache_bridge dut_a (
        .clk(clk), .rst_x(rst_x), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready),
        .hready_resp(hready_resp_a), .hresp(hresp_a), .hrdata(hrdata_a),
        .mem_rd_en(mem_rd_en_a), .mem_wr_en(mem_wr_en_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_mask(mem_mask_a), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .timeout_cnt(timeout_cnt_a)
    );

    ahbl_cache_bridge #(.IGNORE_CYC(2), .TIMEOUT_CYC(16), .CNT_W(5)) dut_b (
        .clk(clk), .rst_x(rst_x), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready),
        .hready_resp(hready_resp_b), .hresp(hresp_b), .hrdata(hrdata_b),
        .mem_rd_en(mem_rd_en_b), .mem_wr_en(mem_wr_en_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_mask(mem_mask_b), .mem_rdata(mem_rdata),
        .mem_busy(mem_busy), .timeout_cnt(timeout_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
    endtask

    // One transfer from address phase up to the first cycle with hready_resp high.
    // mem_busy is high for busy_n cycles starting with the pulse cycle (k=1).
    // Returns with the DUT sitting in that RESP/ERR2 cycle.
    task automatic run_xfer(input bit use_b, input logic wr, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input int busy_n,
                            output int low, output int rdp, output int wrp, output int errc,
                            output logic [3:0] msk, output logic [31:0] ma,
                            output logic [31:0] mwd, output logic [31:0] rdat,
                            output bit got);
        logic rdy, rsp, rp, wp;
        low = 0; rdp = 0; wrp = 0; errc = 0; msk = '0; ma = '0; mwd = '0; rdat = '0; got = 0;
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = sz; haddr = a;
        tick();
        idle_bus();
        hwdata = wd;
        for (int k = 0; k < 80 && !got; k++) begin
            mem_busy = (k >= 1) && (k < 1 + busy_n);
            rdy = use_b ? hready_resp_b : hready_resp_a;
            rsp = use_b ? hresp_b : hresp_a;
            rp  = use_b ? mem_rd_en_b : mem_rd_en_a;
            wp  = use_b ? mem_wr_en_b : mem_wr_en_a;
            if (!rdy) low++;
            if (rsp) errc++;
            if (rp) rdp++;
            if (wp) wrp++;
            if (rp || wp) begin
                msk = use_b ? mem_mask_b : mem_mask_a;
                ma  = use_b ? mem_addr_b : mem_addr_a;
                mwd = use_b ? mem_wdata_b : mem_wdata_a;
            end
            if (rdy) begin
                got  = 1;
                rdat = use_b ? hrdata_b : hrdata_a;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst_x = 1'b0;
        tick(); tick();
        checks++; if (hready_resp_a !== 1'b1) begin errors++; $display("FAIL reset_hready: got %b want 1", hready_resp_a); end
        checks++; if (hresp_a !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b want 0", hresp_a); end
        checks++; if (hrdata_a !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h want 0", hrdata_a); end
        checks++; if ({mem_rd_en_a, mem_wr_en_a} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {mem_rd_en_a, mem_wr_en_a}); end
        checks++; if (mem_mask_a !== 4'h0 || mem_addr_a !== 32'h0 || mem_wdata_a !== 32'h0) begin errors++; $display("FAIL reset_mem: got %h/%h/%h want 0/0/0", mem_mask_a, mem_addr_a, mem_wdata_a); end
        checks++; if (timeout_cnt_a !== 8'h0) begin errors++; $display("FAIL reset_tocnt: got %h want 0", timeout_cnt_a); end
        rst_x = 1'b1;
        tick();
    endtask

    task automatic test_word_read();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        mem_rdata = 32'hDEADBEEF;
        run_xfer(0, 1'b0, 3'd2, 32'h0000_0100, 32'h0, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (!got) begin errors++; $display("FAIL rd_timeout: got no response want response"); end
        checks++; if (rdp !== 1 || wrp !== 0) begin errors++; $display("FAIL rd_pulses: got rd=%0d wr=%0d want 1/0", rdp, wrp); end
        checks++; if (m !== 4'hF) begin errors++; $display("FAIL rd_mask: got %h want f", m); end
        checks++; if (low !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", low); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        checks++; if (errc !== 0) begin errors++; $display("FAIL rd_hresp: got %0d want 0", errc); end
        tick(); tick();
    endtask

    task automatic test_byte_write();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        mem_rdata = 32'h1234_5678;
        run_xfer(0, 1'b1, 3'd0, 32'h0000_0203, 32'hAB00_0000, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (wrp !== 1 || rdp !== 0) begin errors++; $display("FAIL wr_pulses: got rd=%0d wr=%0d want 0/1", rdp, wrp); end
        checks++; if (m !== 4'b1000) begin errors++; $display("FAIL wr_mask: got %b want 1000", m); end
        checks++; if (ma !== 32'h0000_0203) begin errors++; $display("FAIL wr_addr: got %h want 00000203", ma); end
        checks++; if (mwd !== 32'hAB00_0000) begin errors++; $display("FAIL wr_wdata: got %h want ab000000", mwd); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_hrdata_kept: got %h want deadbeef", rd); end
        checks++; if (low !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", low); end
        tick(); tick();
        // Legal half read in the upper half-word carries mask 1100.
        run_xfer(0, 1'b0, 3'd1, 32'h0000_0012, 32'h0, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (m !== 4'b1100 || rd !== 32'h1234_5678) begin errors++; $display("FAIL half_rd: got mask %b data %h want 1100 12345678", m, rd); end
        tick(); tick();
    endtask

    task automatic test_illegal();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        logic [2:0]  sz [3] = '{3'd1, 3'd2, 3'd3};
        logic [31:0] ad [3] = '{32'h0000_0011, 32'h0000_0102, 32'h0000_0000};
        for (int i = 0; i < 3; i++) begin
            run_xfer(0, 1'b0, sz[i], ad[i], 32'h0, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
            checks++; if (rdp !== 0 || wrp !== 0) begin errors++; $display("FAIL ill%0d_pulses: got rd=%0d wr=%0d want 0/0", i, rdp, wrp); end
            checks++; if (errc !== 2 || low !== 1 || !got) begin errors++; $display("FAIL ill%0d_resp: got hresp cycles %0d low %0d want 2/1", i, errc, low); end
            tick(); tick();
        end
    endtask

    task automatic test_ignored();
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h40;
        tick();
        hsel = 1'b0; htrans = 2'b10;
        tick();
        idle_bus();
        checks++; if (hready_resp_a !== 1'b1) begin errors++; $display("FAIL ignored_hready: got %b want 1", hready_resp_a); end
        tick();
        checks++; if (mem_rd_en_a !== 1'b0 || hready_resp_a !== 1'b1) begin errors++; $display("FAIL ignored_pulse: got rd=%b rdy=%b want 0/1", mem_rd_en_a, hready_resp_a); end
    endtask

    task automatic test_timeout();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        mem_rdata = 32'h0000_5555;
        run_xfer(1, 1'b0, 3'd2, 32'h0000_0400, 32'h0, 100, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (low !== 18 || errc !== 2 || !got) begin errors++; $display("FAIL to_resp: got low %0d hresp cycles %0d want 18/2", low, errc); end
        checks++; if (rdp !== 1) begin errors++; $display("FAIL to_pulse: got %0d want 1", rdp); end
        checks++; if (timeout_cnt_b !== 8'd1) begin errors++; $display("FAIL to_cnt: got %0d want 1", timeout_cnt_b); end
        checks++; if (timeout_cnt_a !== 8'd0) begin errors++; $display("FAIL to_cnt_long: got %0d want 0", timeout_cnt_a); end
        mem_busy = 1'b0;
        tick(); tick(); tick(); tick();
        mem_rdata = 32'h0000_AAAA;
        run_xfer(1, 1'b0, 3'd2, 32'h0000_0404, 32'h0, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (low !== 4 || errc !== 0 || rd !== 32'h0000_AAAA) begin errors++; $display("FAIL to_recover: got low %0d err %0d data %h want 4/0/0000aaaa", low, errc, rd); end
        tick(); tick();
    endtask

    task automatic test_busy_stall();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        mem_rdata = 32'h0BAD_CAFE;
        // Busy through WAIT1..WAIT22: the first two fall in the ignore window, 20 stall.
        run_xfer(0, 1'b0, 3'd2, 32'h0000_0500, 32'h0, 22, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (low !== 24) begin errors++; $display("FAIL busy_latency: got %0d want 24", low); end
        checks++; if (rd !== 32'h0BAD_CAFE || rdp !== 1 || errc !== 0) begin errors++; $display("FAIL busy_data: got %h rd=%0d err=%0d want 0badcafe/1/0", rd, rdp, errc); end
        checks++; if (timeout_cnt_b !== 8'd2) begin errors++; $display("FAIL busy_tocnt_b: got %0d want 2", timeout_cnt_b); end
        mem_busy = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int low, rdp, wrp, errc; logic [3:0] m; logic [31:0] ma, mwd, rd; bit got;
        bit done;
        mem_rdata = 32'hCAFE_F00D;
        run_xfer(0, 1'b0, 3'd2, 32'h0000_0600, 32'h0, 0, low, rdp, wrp, errc, m, ma, mwd, rd, got);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rd: got %h want cafef00d", rd); end
        // New write accepted in the RESP cycle.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0000_0300;
        tick();
        idle_bus();
        hwdata = 32'h55AA_55AA;
        checks++; if (hready_resp_a !== 1'b0) begin errors++; $display("FAIL b2b_issue: got hready %b want 0", hready_resp_a); end
        tick();
        checks++; if (mem_wr_en_a !== 1'b1 || mem_rd_en_a !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got wr=%b rd=%b want 1/0", mem_wr_en_a, mem_rd_en_a); end
        checks++; if (mem_addr_a !== 32'h0000_0300 || mem_wdata_a !== 32'h55AA_55AA || mem_mask_a !== 4'hF) begin errors++; $display("FAIL b2b_fields: got %h %h %h want 00000300 55aa55aa f", mem_addr_a, mem_wdata_a, mem_mask_a); end
        done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            if (hready_resp_a) done = 1; else tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL b2b_complete: got no response want response"); end
        tick(); tick();
        // Reset while waiting on a read.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0000_0700;
        tick();
        idle_bus();
        tick();
        rst_x = 1'b0;
        tick();
        checks++; if (hready_resp_a !== 1'b1 || mem_rd_en_a !== 1'b0 || mem_wr_en_a !== 1'b0) begin errors++; $display("FAIL rst_mid: got rdy=%b rd=%b wr=%b want 1/0/0", hready_resp_a, mem_rd_en_a, mem_wr_en_a); end
        checks++; if (hrdata_a !== 32'h0 || mem_addr_a !== 32'h0 || timeout_cnt_b !== 8'h0) begin errors++; $display("FAIL rst_mid_regs: got %h %h %0d want 0 0 0", hrdata_a, mem_addr_a, timeout_cnt_b); end
        rst_x = 1'b1;
        tick();
        checks++; if (hready_resp_a !== 1'b1 || mem_rd_en_a !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: got rdy=%b rd=%b want 1/0", hready_resp_a, mem_rd_en_a); end
    endtask

    initial begin
        rst_x = 1'b0; hready = 1'b1; mem_busy = 1'b0; hwdata = '0; mem_rdata = '0;
        idle_bus();
        test_reset();
        test_word_read();
        test_byte_write();
        test_illegal();
        test_ignored();
        test_timeout();
        test_busy_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
